// File: rtl/clint_trap_ctrl.sv
// rtl/clint_trap_ctrl.sv - core-local trap sequencer between EX and the CSR file
//
// Purpose: accepts ecall/ebreak, the level timer interrupt and mret from EX,
// performs the required mepc/mcause/mstatus writes through the CSR file's
// clint write port, then issues a one-cycle PC redirect to mtvec or mepc.
// The pipeline is held from acceptance until the redirect cycle.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   inst_valid_i, inst_addr_i    EX instruction valid and PC
//   ecall_i, ebreak_i, mret_i    EX instruction decode (qualified by inst_valid_i)
//   int_req_i, global_int_en_i   level timer interrupt, mstatus.MIE
//   csr_mtvec_i/mepc_i/mstatus_i current CSR values
//   csr_wb_we_i                  WB owns the CSR write port this cycle
//   csr_we_o/waddr_o/wdata_o     CSR write port
//   hold_o                       stall IF/ID/EX
//   jump_o, jump_addr_o          one-cycle PC redirect

module clint_trap_ctrl #(
    parameter int XLEN   = 64,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_valid_i,
    input  logic [XLEN-1:0]   inst_addr_i,
    input  logic              ecall_i,
    input  logic              ebreak_i,
    input  logic              mret_i,
    input  logic              int_req_i,
    input  logic              global_int_en_i,
    input  logic [XLEN-1:0]   csr_mtvec_i,
    input  logic [XLEN-1:0]   csr_mepc_i,
    input  logic [XLEN-1:0]   csr_mstatus_i,
    input  logic              csr_wb_we_i,
    output logic              csr_we_o,
    output logic [CSR_AW-1:0] csr_waddr_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    output logic              hold_o,
    output logic              jump_o,
    output logic [XLEN-1:0]   jump_addr_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_MEPC,
        S_W_MCAUSE,
        S_W_MSTATUS,
        S_M_MSTATUS,
        S_JUMP
    } state_t;

    localparam logic [CSR_AW-1:0] ADDR_MSTATUS = CSR_AW'(12'h300);
    localparam logic [CSR_AW-1:0] ADDR_MEPC    = CSR_AW'(12'h341);
    localparam logic [CSR_AW-1:0] ADDR_MCAUSE  = CSR_AW'(12'h342);

    localparam logic [XLEN-1:0] CAUSE_ECALL  = XLEN'(11);
    localparam logic [XLEN-1:0] CAUSE_EBREAK = XLEN'(3);
    localparam logic [XLEN-1:0] CAUSE_MTI    = {1'b1, (XLEN-1)'(7)};
    // Direct mode only: the mode field in mtvec[1:0] is dropped from the target.
    localparam logic [XLEN-1:0] VEC_MASK     = ~XLEN'(3);

    state_t            state, state_nxt;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic [XLEN-1:0]   cause_q, cause_d;
    logic              mret_q, mret_d;

    logic              take_exc;
    logic              take_int;
    logic              take_mret;
    logic [XLEN-1:0]   mstatus_trap;
    logic [XLEN-1:0]   mstatus_mret;

    // Acceptance is gated by rst_n so no output can rise while reset is held.
    assign take_exc  = rst_n & inst_valid_i & (ecall_i | ebreak_i);
    assign take_int  = rst_n & inst_valid_i & int_req_i & global_int_en_i;
    assign take_mret = rst_n & inst_valid_i & mret_i;

    // mstatus is read in the write state itself so earlier WB writes are kept.
    always_comb begin
        mstatus_trap        = csr_mstatus_i;
        mstatus_trap[7]     = csr_mstatus_i[3];
        mstatus_trap[3]     = 1'b0;
        mstatus_trap[12:11] = 2'b11;

        mstatus_mret        = csr_mstatus_i;
        mstatus_mret[3]     = csr_mstatus_i[7];
        mstatus_mret[7]     = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            epc_q   <= '0;
            cause_q <= '0;
            mret_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            mret_q  <= mret_d;
        end
    end

    always_comb begin
        state_nxt   = state;
        epc_d       = epc_q;
        cause_d     = cause_q;
        mret_d      = mret_q;
        csr_we_o    = 1'b0;
        csr_waddr_o = '0;
        csr_wdata_o = '0;
        hold_o      = 1'b0;
        jump_o      = 1'b0;
        jump_addr_o = '0;

        case (state)
            S_IDLE: begin
                // Exceptions win over the interrupt; a pending interrupt is
                // then masked by the MIE clear in the trap sequence.
                if (take_exc || take_int) begin
                    hold_o    = 1'b1;
                    epc_d     = inst_addr_i;
                    mret_d    = 1'b0;
                    state_nxt = S_W_MEPC;
                    if (ecall_i && inst_valid_i) begin
                        cause_d = CAUSE_ECALL;
                    end else if (ebreak_i && inst_valid_i) begin
                        cause_d = CAUSE_EBREAK;
                    end else begin
                        cause_d = CAUSE_MTI;
                    end
                end else if (take_mret) begin
                    hold_o    = 1'b1;
                    mret_d    = 1'b1;
                    state_nxt = S_M_MSTATUS;
                end
            end
            // While WB owns the port the CSR file drops our write, so the
            // state is held and the same write is presented again.
            S_W_MEPC: begin
                hold_o      = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MEPC;
                csr_wdata_o = epc_q;
                if (!csr_wb_we_i) state_nxt = S_W_MCAUSE;
            end
            S_W_MCAUSE: begin
                hold_o      = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MCAUSE;
                csr_wdata_o = cause_q;
                if (!csr_wb_we_i) state_nxt = S_W_MSTATUS;
            end
            S_W_MSTATUS: begin
                hold_o      = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MSTATUS;
                csr_wdata_o = mstatus_trap;
                if (!csr_wb_we_i) state_nxt = S_JUMP;
            end
            S_M_MSTATUS: begin
                hold_o      = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MSTATUS;
                csr_wdata_o = mstatus_mret;
                if (!csr_wb_we_i) state_nxt = S_JUMP;
            end
            S_JUMP: begin
                hold_o      = 1'b1;
                jump_o      = 1'b1;
                jump_addr_o = mret_q ? csr_mepc_i : (csr_mtvec_i & VEC_MASK);
                state_nxt   = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_clint_trap_ctrl.sv
// tb/tb_clint_trap_ctrl.sv - scoreboard bench for clint_trap_ctrl
module tb_clint_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid_i;
    logic [63:0] inst_addr_i;
    logic        ecall_i, ebreak_i, mret_i, int_req_i, global_int_en_i;
    logic [63:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic        csr_wb_we_i;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [63:0] csr_wdata_o;
    logic        hold_o, jump_o;
    logic [63:0] jump_addr_o;

    clint_trap_ctrl #(.XLEN(64), .CSR_AW(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_valid_i(inst_valid_i), .inst_addr_i(inst_addr_i),
        .ecall_i(ecall_i), .ebreak_i(ebreak_i), .mret_i(mret_i),
        .int_req_i(int_req_i), .global_int_en_i(global_int_en_i),
        .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
        .csr_wb_we_i(csr_wb_we_i),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .hold_o(hold_o), .jump_o(jump_o), .jump_addr_o(jump_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_jump;
        logic [11:0] addr;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    bit   exp_hold = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference rules for the mstatus rewrite, as plain bit arithmetic.
    function automatic logic [63:0] ref_trap_mstatus(input logic [63:0] m);
        return (m & ~64'h88) | (((m >> 3) & 64'h1) << 7) | 64'h1800;
    endfunction

    function automatic logic [63:0] ref_mret_mstatus(input logic [63:0] m);
        return (m & ~64'h88) | (((m >> 7) & 64'h1) << 3) | 64'h80;
    endfunction

    // Monitor: pops expected writes/jumps when the DUT presents them.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_hold", {63'd0, hold_o}, 64'd0);
            chk("rst_we", {63'd0, csr_we_o}, 64'd0);
            chk("rst_waddr", {52'd0, csr_waddr_o}, 64'd0);
            chk("rst_wdata", csr_wdata_o, 64'd0);
            chk("rst_jump", {63'd0, jump_o}, 64'd0);
            chk("rst_jaddr", jump_addr_o, 64'd0);
        end else begin
            chk("hold", {63'd0, hold_o}, {63'd0, exp_hold});
            if (csr_we_o) begin
                if (q.size() == 0 || q[0].is_jump) begin
                    chk("spurious_we", {63'd0, csr_we_o}, 64'd0);
                end else begin
                    chk("waddr", {52'd0, csr_waddr_o}, {52'd0, q[0].addr});
                    chk("wdata", csr_wdata_o, q[0].data);
                    if (!csr_wb_we_i) begin
                        chk("write_cycle", 64'(cyc), 64'(q[0].cyc));
                        void'(q.pop_front());
                    end
                end
            end else begin
                chk("idle_waddr", {52'd0, csr_waddr_o}, 64'd0);
                chk("idle_wdata", csr_wdata_o, 64'd0);
            end
            if (jump_o) begin
                if (q.size() == 0 || !q[0].is_jump) begin
                    chk("spurious_jump", {63'd0, jump_o}, 64'd0);
                end else begin
                    chk("jump_addr", jump_addr_o, q[0].data);
                    chk("jump_cycle", 64'(cyc), 64'(q[0].cyc));
                    void'(q.pop_front());
                end
            end else begin
                chk("idle_jaddr", jump_addr_o, 64'd0);
            end
            while (q.size() > 0 && q[0].cyc < cyc) begin
                chk("missed_event_cycle", 64'(cyc), 64'(q[0].cyc));
                void'(q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        inst_valid_i = 0; ecall_i = 0; ebreak_i = 0; mret_i = 0;
        int_req_i = 0; global_int_en_i = 0; csr_wb_we_i = 0;
        inst_addr_i = 64'd0;
    endtask

    task automatic rand_events();
        inst_valid_i    = 1'($urandom);
        ecall_i         = 1'($urandom);
        ebreak_i        = 1'($urandom);
        mret_i          = 1'($urandom);
        int_req_i       = 1'($urandom);
        global_int_en_i = 1'($urandom);
        inst_addr_i     = {$urandom, $urandom};
    endtask

    // mode 0: no WB conflicts; 1: random conflicts; 2: two conflict cycles on the 2nd write
    task automatic do_event(input bit v, input bit e, input bit b, input bit m,
                            input bit ir, input bit mie,
                            input logic [63:0] pc, input logic [63:0] mtvec,
                            input logic [63:0] mepc, input logic [63:0] mstatus,
                            input int mode);
        bit          trap, ret;
        int          nw, t;
        int          stalls[3];
        logic [11:0] addrs[3];
        logic [63:0] datas[3];
        logic [63:0] cause;
        bit          wbq[$];
        exp_t        ex;

        inst_valid_i = v; ecall_i = e; ebreak_i = b; mret_i = m;
        int_req_i = ir; global_int_en_i = mie; inst_addr_i = pc;
        csr_mtvec_i = mtvec; csr_mepc_i = mepc; csr_mstatus_i = mstatus;
        csr_wb_we_i = 0;

        trap = v && (e || b || (ir && mie));
        ret  = v && !trap && m;
        if (!trap && !ret) begin
            exp_hold = 0;
            step();
            clear_events();
            return;
        end
        exp_hold = 1;

        cause = e ? 64'd11 : (b ? 64'd3 : 64'h8000_0000_0000_0007);
        if (trap) begin
            nw = 3;
            addrs[0] = 12'h341; datas[0] = pc;
            addrs[1] = 12'h342; datas[1] = cause;
            addrs[2] = 12'h300; datas[2] = ref_trap_mstatus(mstatus);
        end else begin
            nw = 1;
            addrs[0] = 12'h300; datas[0] = ref_mret_mstatus(mstatus);
        end

        t = cyc + 1;
        for (int k = 0; k < nw; k++) begin
            if (mode == 0)      stalls[k] = 0;
            else if (mode == 2) stalls[k] = (k == 1) ? 2 : 0;
            else                stalls[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            t += stalls[k];
            ex.is_jump = 0; ex.addr = addrs[k]; ex.data = datas[k]; ex.cyc = t;
            q.push_back(ex);
            for (int s = 0; s < stalls[k]; s++) wbq.push_back(1'b1);
            wbq.push_back(1'b0);
            t++;
        end
        ex.is_jump = 1; ex.addr = 12'h0;
        ex.data = trap ? (mtvec & ~64'h3) : mepc;
        ex.cyc = t;
        q.push_back(ex);

        step();
        foreach (wbq[i]) begin
            rand_events();
            csr_wb_we_i = wbq[i];
            step();
        end
        rand_events();
        csr_wb_we_i = 1'($urandom);
        step();
        exp_hold = 0;
        clear_events();
    endtask

    // ecall, then reset asserted while the mcause write is pending.
    task automatic reset_mid_sequence();
        exp_t ex;
        inst_valid_i = 1; ecall_i = 1; inst_addr_i = 64'h8000_0040;
        csr_mtvec_i = 64'h8000_0100; csr_mstatus_i = 64'h8;
        exp_hold = 1;
        ex.is_jump = 0; ex.addr = 12'h341; ex.data = 64'h8000_0040; ex.cyc = cyc + 1;
        q.push_back(ex);
        step();
        clear_events();
        step();
        rst_n = 0;
        q.delete();
        step();
        step();
        rst_n = 1;
        exp_hold = 0;
        repeat (4) step();
    endtask

    initial begin
        rst_n = 0;
        clear_events();
        csr_mtvec_i = 0; csr_mepc_i = 0; csr_mstatus_i = 0;
        repeat (3) step();
        rst_n = 1;
        step();

        do_event(1, 1, 0, 0, 0, 0, 64'h8000_0010, 64'h8000_0100, 64'h0, 64'h8, 0);
        do_event(1, 0, 0, 0, 1, 1, 64'h8000_0020, 64'h8000_0101, 64'h0, 64'h8, 0);
        do_event(1, 0, 0, 0, 1, 0, 64'h8000_0020, 64'h8000_0100, 64'h0, 64'h8, 0);
        do_event(0, 1, 0, 1, 1, 1, 64'h8000_0030, 64'h8000_0100, 64'h0, 64'h8, 0);
        do_event(1, 0, 0, 1, 0, 0, 64'h0, 64'h8000_0100, 64'h8000_0024, 64'h1880, 0);
        do_event(1, 1, 0, 0, 0, 0, 64'h8000_0050, 64'h8000_0200, 64'h0, 64'h8, 2);
        do_event(1, 1, 0, 0, 1, 1, 64'h8000_0060, 64'h8000_0300, 64'h0, 64'h8, 0);
        do_event(1, 0, 1, 0, 0, 0, 64'h8000_0070, 64'h8000_0403, 64'h0, 64'h0, 0);
        reset_mid_sequence();

        for (int i = 0; i < 200; i++) begin
            do_event($urandom_range(0, 7) != 0,
                     $urandom_range(0, 4) == 0,
                     $urandom_range(0, 4) == 0,
                     $urandom_range(0, 2) == 0,
                     1'($urandom), 1'($urandom),
                     {$urandom, $urandom}, {$urandom, $urandom},
                     {$urandom, $urandom}, {$urandom, $urandom},
                     $urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) step();
        end

        repeat (3) step();
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
